// File: rtl/pipeline_register_if.sv
// rtl/pipeline_register_if.sv - control and data bundle for one pipeline register stage
interface pipeline_register_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             stall;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;

    modport master (
        output flush,
        output stall,
        output in,
        input  out
    );

    modport slave (
        input  flush,
        input  stall,
        input  in,
        output out
    );
endinterface

// File: rtl/pipeline_register.sv
// rtl/pipeline_register.sv - single-stage pipeline register with stall hold and flush bubble
module pipeline_register #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] reset = '0
) (
    input  logic               clk,
    input  logic               rst,
    pipeline_register_if.slave bus
);
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;

    // Next value: flush inserts the bubble value and beats stall; stall holds; else load in.
    always_comb begin
        out_d = bus.in;
        if (bus.flush) begin
            out_d = reset;
        end else if (bus.stall) begin
            out_d = out_q;
        end
    end

    // The stage register; synchronous reset has top priority over flush and stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= reset;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;
endmodule

// File: tb/tb_pipeline_register.sv
// tb/tb_pipeline_register.sv - scoreboard bench over four width/bubble-value configurations
module tb_pipeline_register;
    typedef struct packed {
        logic        r;
        logic        f;
        logic        s;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0;

    pipeline_register_if #(.WIDTH(32)) if_a ();
    pipeline_register_if #(.WIDTH(2))  if_b ();
    pipeline_register_if #(.WIDTH(1))  if_c ();
    pipeline_register_if #(.WIDTH(1))  if_d ();

    pipeline_register #(.WIDTH(32), .reset(32'h0)) dut_a (.clk(clk), .rst(rst_a), .bus(if_a));
    pipeline_register #(.WIDTH(2),  .reset(2'b11)) dut_b (.clk(clk), .rst(rst_b), .bus(if_b));
    pipeline_register #(.WIDTH(1),  .reset(1'b0))  dut_c (.clk(clk), .rst(rst_c), .bus(if_c));
    pipeline_register #(.WIDTH(1),  .reset(1'b1))  dut_d (.clk(clk), .rst(rst_d), .bus(if_d));

    int total = 0;
    int bad   = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [31:0] q_c[$];
    logic [31:0] q_d[$];

    vec_t va[$];
    vec_t vb[$];
    vec_t vc[$];
    vec_t vd[$];

    function automatic vec_t mk(logic r, logic f, logic s, logic [31:0] d, logic [31:0] e);
        vec_t v;
        v.r = r; v.f = f; v.s = s; v.d = d; v.e = e;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(int id, vec_t v);
        case (id)
            0: begin rst_a = v.r; if_a.flush = v.f; if_a.stall = v.s; if_a.in = v.d;      q_a.push_back(v.e); end
            1: begin rst_b = v.r; if_b.flush = v.f; if_b.stall = v.s; if_b.in = v.d[1:0]; q_b.push_back(v.e); end
            2: begin rst_c = v.r; if_c.flush = v.f; if_c.stall = v.s; if_c.in = v.d[0];   q_c.push_back(v.e); end
            default: begin rst_d = v.r; if_d.flush = v.f; if_d.stall = v.s; if_d.in = v.d[0]; q_d.push_back(v.e); end
        endcase
    endtask

    // Monitor: after every rising edge, pop each instance's expected value and compare.
    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) check("w32_r0", if_a.out, q_a.pop_front());
        if (q_b.size() > 0) check("w2_r3", {30'b0, if_b.out}, q_b.pop_front());
        if (q_c.size() > 0) check("w1_r0", {31'b0, if_c.out}, q_c.pop_front());
        if (q_d.size() > 0) check("w1_r1", {31'b0, if_d.out}, q_d.pop_front());
    end

    initial begin
        if_a.flush = 1'b0; if_a.stall = 1'b0; if_a.in = '0;
        if_b.flush = 1'b0; if_b.stall = 1'b0; if_b.in = '0;
        if_c.flush = 1'b0; if_c.stall = 1'b0; if_c.in = '0;
        if_d.flush = 1'b0; if_d.stall = 1'b0; if_d.in = '0;

        //            r     f     s     in            expected after edge
        va.push_back(mk(1'b1, 1'b0, 1'b0, 32'h12345678, 32'h0));
        va.push_back(mk(1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF));
        va.push_back(mk(1'b0, 1'b0, 1'b0, 32'h1,        32'h1));
        va.push_back(mk(1'b0, 1'b0, 1'b0, 32'h2,        32'h2));
        va.push_back(mk(1'b0, 1'b0, 1'b0, 32'h3,        32'h3));
        va.push_back(mk(1'b0, 1'b0, 1'b0, 32'hA5,       32'hA5));
        va.push_back(mk(1'b0, 1'b0, 1'b1, 32'h11,       32'hA5));
        va.push_back(mk(1'b0, 1'b0, 1'b1, 32'h22,       32'hA5));
        va.push_back(mk(1'b0, 1'b0, 1'b1, 32'h33,       32'hA5));
        va.push_back(mk(1'b0, 1'b0, 1'b0, 32'h44,       32'h44));
        va.push_back(mk(1'b0, 1'b1, 1'b1, 32'h55,       32'h0));
        va.push_back(mk(1'b0, 1'b0, 1'b0, 32'h77,       32'h77));
        va.push_back(mk(1'b1, 1'b0, 1'b1, 32'h66,       32'h0));

        vb.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h3));
        vb.push_back(mk(1'b0, 1'b0, 1'b0, 32'h1, 32'h1));
        vb.push_back(mk(1'b0, 1'b1, 1'b1, 32'h0, 32'h3));
        vb.push_back(mk(1'b0, 1'b0, 1'b0, 32'h2, 32'h2));
        vb.push_back(mk(1'b0, 1'b0, 1'b1, 32'h1, 32'h2));
        vb.push_back(mk(1'b0, 1'b1, 1'b0, 32'h1, 32'h3));

        vc.push_back(mk(1'b1, 1'b0, 1'b0, 32'h1, 32'h0));
        vc.push_back(mk(1'b0, 1'b0, 1'b0, 32'h1, 32'h1));
        vc.push_back(mk(1'b1, 1'b0, 1'b1, 32'h1, 32'h0));
        vc.push_back(mk(1'b0, 1'b0, 1'b0, 32'h1, 32'h1));
        vc.push_back(mk(1'b1, 1'b1, 1'b0, 32'h1, 32'h0));
        vc.push_back(mk(1'b0, 1'b0, 1'b0, 32'h1, 32'h1));
        vc.push_back(mk(1'b0, 1'b1, 1'b0, 32'h1, 32'h0));

        vd.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h1));
        vd.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
        vd.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 32'h1));
        vd.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 32'h1));
        vd.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
        vd.push_back(mk(1'b0, 1'b0, 1'b0, 32'h1, 32'h1));

        fork
            begin
                foreach (va[i]) begin
                    @(negedge clk);
                    drive(0, va[i]);
                    if (i == 1) begin
                        #1;
                        check("w32_no_early_load", if_a.out, 32'h0);
                    end
                end
            end
            begin
                foreach (vb[i]) begin
                    @(negedge clk);
                    drive(1, vb[i]);
                end
            end
            begin
                foreach (vc[i]) begin
                    @(negedge clk);
                    drive(2, vc[i]);
                end
            end
            begin
                foreach (vd[i]) begin
                    @(negedge clk);
                    drive(3, vd[i]);
                end
            end
        join

        begin
            int budget = 20;
            while ((q_a.size() + q_b.size() + q_c.size() + q_d.size()) > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (budget == 0) begin
                total++;
                bad++;
                $display("FAIL drain_timeout: pending=%0d want 0",
                         q_a.size() + q_b.size() + q_c.size() + q_d.size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_register.md
Name: pipeline_register

Overview:
- Generic single-stage pipeline register carrying one data field of parameterizable width between adjacent pipeline stages.
- Controller instantiates one per control signal (reg_wr, mem_wr, wb_sel, PC_sel, mem_read, is_mret, csr_reg_r, csr_reg_wr); datapath uses it for wider fields.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
WIDTH, 32, bit width of in/out.
reset, 0, value loaded on rst and on flush (bubble value), truncated/zero-extended to WIDTH.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset; instances without a reset source tie it to 0.
flush  input  1  synchronous bubble: replace stored value with parameter reset.
stall  input  1  synchronous hold: keep stored value.
in  input  WIDTH  next-stage data.
out  output  WIDTH  registered data, driven directly from the flop (no combinational path from any input).

Behaviour:
- All updates on rising clk edge only; out changes only after an edge.
- Priority per edge, highest first:
  1. rst=1 -> out <= reset.
  2. flush=1 -> out <= reset. Flush overrides stall.
  3. stall=1 -> out <= out (hold).
  4. otherwise -> out <= in.
- Latency: exactly one cycle from in to out when neither stall nor flush is asserted.
- Stall is multi-cycle capable: value held for every edge stall stays high; the edge after deassertion loads the current in.
- Flush lasts one edge per assertion; held high, out stays at reset each edge.
- rst mid-stall or mid-flush: rst wins; out = reset after that edge.
- Power-up before first rst: out undefined (X in simulation); no initial block.
- in is sampled only at the edge; glitches between edges have no effect.
- X on stall/flush: no masking requirement; simulation may propagate X.
- Width rules:
  - WIDTH >= 1.
  - reset parameter is cast to WIDTH bits (low WIDTH bits kept).
  - With WIDTH=1 and reset=0, a flushed control bit deasserts (e.g. reg_wr/mem_wr become 0, killing the flushed instruction's side effects).
- No internal state beyond the WIDTH-bit register.
- Synthesizable; infers WIDTH flops with sync reset and clock-enable style hold.

Test Plan:
- WIDTH=32, reset=0: rst=1 one edge -> out=0x00000000; release rst, in=0xDEADBEEF, stall=flush=0 -> after next edge out=0xDEADBEEF, not before.
- Stream 1,2,3 on in over three edges, no stall/flush -> out follows 1,2,3 one cycle late.
- out=0xA5, stall=1 for 3 edges while in=0x11,0x22,0x33 -> out stays 0xA5; stall=0 with in=0x44 -> next edge out=0x44.
- WIDTH=2, reset=2'b11, out=2'b01: flush=1 and stall=1 on the same edge -> out=2'b11; flush=0, stall=0, in=2'b10 -> out=2'b10.
- WIDTH=1, reset=0, out=1: rst=1 with flush=0, stall=1, in=1 -> out=0 (rst beats stall); rst=1 and flush=1 together -> out=0.
- WIDTH=1, reset=1: flush held 2 edges with in=0 -> out=1 both cycles; release -> out=0 after next edge.
